// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline sequencer for the 5-stage RV32I core.
//   - Merges stall requests from IF/ID/EX/MEM into a 6-bit hold vector
//     (bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 WB).
//     The deepest requester wins; bit5 is never set.
//   - Sequences taken-branch flushes and PC redirects. A flush is deferred
//     while EX is frozen, and a redirect is held until the PC is free to load.
//   - Keeps saturating stall-cycle and flush counters for performance debug.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_if/id/ex/mem   per-stage stall requests
//   br_taken/target    taken branch resolved in EX and its target
//   clr_cnt            synchronous clear of both counters
//   stall              hold vector to the pipeline registers
//   flush_ifid/idex    one-cycle bubble pulses
//   pc_redirect        PC loads pc_target when stall[0] is low
//   pc_target          redirect address
//   busy               flush pending or redirect outstanding
//   stall_cycles       cycles with the PC held (saturating)
//   flush_count        flushes issued (saturating)
// While rst is high every output reads as zero and requests are masked.
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_if,
    input  logic              req_id,
    input  logic              req_ex,
    input  logic              req_mem,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              clr_cnt,
    output logic [5:0]        stall,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] tgt_r;
    logic [ADDR_W-1:0] tgt_nxt_s;
    logic [ADDR_W-1:0] target_s;
    logic [5:0]        stall_s;
    logic              issue_s;
    logic              redir_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    // Stall vector: deepest requester wins; requests masked during reset.
    always_comb begin
        stall_s = 6'b000000;
        if (rst) begin
            stall_s = 6'b000000;
        end else if (req_mem) begin
            stall_s = 6'b011111;
        end else if (req_ex) begin
            stall_s = 6'b001111;
        end else if (req_id) begin
            stall_s = 6'b000111;
        end else if (req_if) begin
            stall_s = 6'b000011;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Branch sequencer: next state, target latch and flush/redirect decode.
    always_comb begin
        state_nxt_s = state_r;
        tgt_nxt_s   = tgt_r;
        target_s    = tgt_r;
        issue_s     = 1'b0;
        redir_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (br_taken) begin
                    // Target is latched either way so PEND/REDIR can replay it.
                    tgt_nxt_s = br_target;
                    if (!stall_s[3]) begin
                        issue_s     = 1'b1;
                        redir_s     = 1'b1;
                        target_s    = br_target;
                        state_nxt_s = stall_s[0] ? REDIR : IDLE;
                    end else begin
                        state_nxt_s = PEND;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PEND: begin
                // br_taken is re-asserted by the stalled branch; ignore it here.
                if (!stall_s[3]) begin
                    issue_s     = 1'b1;
                    redir_s     = 1'b1;
                    state_nxt_s = stall_s[0] ? REDIR : IDLE;
                end else begin
                    state_nxt_s = PEND;
                end
            end
            REDIR: begin
                redir_s = 1'b1;
                if (!stall_s[0]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REDIR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tgt_r   <= ADDR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            tgt_r   <= tgt_nxt_s;
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else if (clr_cnt) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_s[0] && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (issue_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall        = stall_s;
    assign flush_ifid   = issue_s & ~rst;
    assign flush_idex   = issue_s & ~rst;
    assign pc_redirect  = redir_s & ~rst;
    assign pc_target    = rst ? ADDR_ZERO : target_s;
    assign busy         = (state_r != IDLE) & ~rst;
    assign stall_cycles = rst ? CNT_ZERO : stall_cnt_r;
    assign flush_count  = rst ? CNT_ZERO : flush_cnt_r;

endmodule
